serial_adder_nbit: RTL

Multi-cycle digit-serial N-bit adder/subtractor. It processes W bits per clock, LSB chunk first, with the carry held in a register between chunks. It trades latency for area against the flat N-bit ripple adder. It is used wherever wide operands and a start/done handshake are acceptable (accumulators, ALU datapaths in later lab exercises).

---
 rtl/serial_adder_nbit_pkg.sv | 19 +
 rtl/fa_chunk.sv | 23 ++
 rtl/serial_adder_nbit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_nbit_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_nbit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Operand width must split evenly into chunks of at least one bit.
  function automatic bit chunk_cfg_ok(int unsigned n, int unsigned w);
    return (n >= 1) && (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

  function automatic int unsigned cnt_width(int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational W-bit ripple-carry adder made of full-adder cells.
module fa_chunk #(
  parameter int unsigned W = 2
) (
  output logic         cout,
  output logic [W-1:0] sum,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/serial_adder_nbit.sv
// Digit-serial N-bit adder/subtractor, W bits per cycle, start/done handshake.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_nbit
  import serial_adder_nbit_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         ripin,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  output logic [N-1:0] somma,
  output logic         ripout,
`ifdef SERIAL_ADD_OVF_EN
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done
);

  localparam int unsigned CHUNKS = N / W;
  localparam int unsigned CntW   = cnt_width(CHUNKS);

  if (!chunk_cfg_ok(N, W)) begin : g_bad_cfg
    $error("serial_adder_nbit: need 1 <= W <= N and N %% W == 0");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    somma_q, somma_d;
  logic            ripout_q, ripout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [31:0]     idx;
  logic [W-1:0]    a_c, b_c, sum_c;
  logic            cout_c;
  logic            accept;

  assign idx = 32'(cnt_q) * W;
  assign a_c = a_q[idx +: W];
  assign b_c = b_q[idx +: W];

  fa_chunk #(
    .W (W)
  ) u_fa_chunk (
    .cout (cout_c),
    .sum  (sum_c),
    .cin  (carry_q),
    .a    (a_c),
    .b    (b_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    somma_d  = somma_q;
    ripout_d = ripout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    accept   = 1'b0;

    unique case (state_q)
      StIdle: accept = start;
      StRun: begin
        somma_d[idx +: W] = sum_c;
        carry_d           = cout_c;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == CntW'(CHUNKS - 1)) begin
          ripout_d = cout_c;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB is recovered from that bit's sum and operands.
          ovf_d    = cout_c ^ (a_c[W-1] ^ b_c[W-1] ^ sum_c[W-1]);
`endif
          state_d  = StDone;
        end
      end
      StDone: begin
        accept  = start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Subtraction is x1 + ~x2 + 1, so ripin is irrelevant when sub is set.
    if (accept) begin
      a_d     = x1;
      b_d     = sub ? ~x2 : x2;
      carry_d = sub ? 1'b1 : ripin;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      somma_q  <= '0;
      ripout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      somma_q  <= somma_d;
      ripout_q <= ripout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign somma  = somma_q;
  assign ripout = ripout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf    = ovf_q;
`endif
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule
